// File: rtl/cnn_stream_pkg.sv
// Shared types and helpers for the CNN stream width converters.
// Lane ordering codes and beat-count math are common to the P2S and S2P blocks.
package cnn_stream_pkg;

    localparam int LANE_WIDTH_DEFAULT = 8;
    typedef logic [LANE_WIDTH_DEFAULT-1:0] lane_t;

    localparam int LANE_ORDER_STRIDED = 0;
    localparam int LANE_ORDER_CONTIG  = 1;

    function automatic int nb_beats(input int bus_i, input int bus_o);
        return (bus_o > 0) ? (bus_i / bus_o) : 1;
    endfunction

    // Word lane carried by output lane 'lane' on beat 'beat'.
    function automatic int lane_src(input int order, input int nb, input int bus_o,
                                    input int beat, input int lane);
        return (order == LANE_ORDER_CONTIG) ? (beat * bus_o + lane) : (beat + nb * lane);
    endfunction

endpackage

// File: rtl/par2ser_stream_if.sv
// Word-in / beat-out stream bundle for par2ser_stream.
// The slave modport is the converter's view; master is the surrounding logic's view.
interface par2ser_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_NUM_I  = 8,
    parameter int BUS_NUM_O  = 1
);
    logic                  data_valid_i;
    logic                  data_ready_o;
    logic [DATA_WIDTH-1:0] data_i [BUS_NUM_I];
    logic                  data_valid_o;
    logic                  data_ready_i;
    logic [DATA_WIDTH-1:0] data_o [BUS_NUM_O];
    logic                  first_o;
    logic                  last_o;

    modport slave (
        input  data_valid_i, data_i, data_ready_i,
        output data_ready_o, data_valid_o, data_o, first_o, last_o
    );

    modport master (
        output data_valid_i, data_i, data_ready_i,
        input  data_ready_o, data_valid_o, data_o, first_o, last_o
    );
endinterface

// File: rtl/p2s_lane_mux.sv
// Selects the output lanes of one beat from a held word, per lane ordering.
// Purely combinational; shared with the serial-to-parallel inverse.
module p2s_lane_mux
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_NUM_I  = 8,
    parameter int BUS_NUM_O  = 1,
    parameter int LANE_ORDER = LANE_ORDER_STRIDED,
    parameter int BEAT_W     = 3
) (
    input  logic [DATA_WIDTH-1:0] word_i  [BUS_NUM_I],
    input  logic [BEAT_W-1:0]     beat_i,
    output logic [DATA_WIDTH-1:0] lanes_o [BUS_NUM_O]
);
    localparam int NB = nb_beats(BUS_NUM_I, BUS_NUM_O);

    // Every source index is a constant per (beat, lane): a plain select tree.
    always_comb begin
        for (int i = 0; i < BUS_NUM_O; i++) begin
            lanes_o[i] = '0;
            for (int k = 0; k < NB; k++) begin
                if (beat_i == BEAT_W'(k)) begin
                    lanes_o[i] = word_i[lane_src(LANE_ORDER, NB, BUS_NUM_O, k, i)];
                end
            end
        end
    end

endmodule

// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter: one BUS_NUM_I-lane word out as NB beats of BUS_NUM_O lanes.
// Latency 1 cycle to beat 0; ready stalls while beats remain, reopens on the last beat's transfer.
module par2ser_stream
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_NUM_I  = 8,
    parameter int BUS_NUM_O  = 1,
    parameter int LANE_ORDER = LANE_ORDER_STRIDED
) (
    input  logic           clk,
    input  logic           reset,
    par2ser_stream_if.slave io
);
    localparam int NB = nb_beats(BUS_NUM_I, BUS_NUM_O);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    if (BUS_NUM_I % BUS_NUM_O != 0) begin : g_bad_ratio
        $error("par2ser_stream: BUS_NUM_I must be a multiple of BUS_NUM_O");
    end

    logic [DATA_WIDTH-1:0] word_q [BUS_NUM_I];
    logic [DATA_WIDTH-1:0] word_d [BUS_NUM_I];
    logic                  full_q, full_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  at_last, out_xfer, in_xfer, ready;
    logic [DATA_WIDTH-1:0] lanes [BUS_NUM_O];

    always_comb begin
        at_last  = (beat_q == LAST_BEAT);
        out_xfer = full_q && io.data_ready_i;
        // Reopening on the last beat's transfer lets the next word load with no bubble.
        ready    = !full_q || (out_xfer && at_last);
        in_xfer  = io.data_valid_i && ready;

        word_d = word_q;
        full_d = full_q;
        beat_d = beat_q;
        if (in_xfer) begin
            word_d = io.data_i;
            full_d = 1'b1;
            beat_d = '0;
        end else if (out_xfer) begin
            if (at_last) begin
                full_d = 1'b0;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            beat_q <= '0;
        end else begin
            full_q <= full_d;
            beat_q <= beat_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    p2s_lane_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_NUM_I  (BUS_NUM_I),
        .BUS_NUM_O  (BUS_NUM_O),
        .LANE_ORDER (LANE_ORDER),
        .BEAT_W     (BW)
    ) u_lane_mux (
        .word_i  (word_q),
        .beat_i  (beat_q),
        .lanes_o (lanes)
    );

    assign io.data_ready_o = ready;
    assign io.data_valid_o = full_q;
    assign io.first_o      = full_q && (beat_q == '0);
    assign io.last_o       = full_q && at_last;
    assign io.data_o       = lanes;

endmodule

// File: tb/tb_par2ser_stream.sv
// Bench for par2ser_stream: four configurations, directed scenarios plus a randomized stream
// checked against a queue-of-beats reference model.
module tb_par2ser_stream;
    import cnn_stream_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    par2ser_stream_if #(.DATA_WIDTH(8), .BUS_NUM_I(8), .BUS_NUM_O(1)) if0 ();
    par2ser_stream_if #(.DATA_WIDTH(8), .BUS_NUM_I(8), .BUS_NUM_O(2)) if1 ();
    par2ser_stream_if #(.DATA_WIDTH(8), .BUS_NUM_I(8), .BUS_NUM_O(2)) if2 ();
    par2ser_stream_if #(.DATA_WIDTH(8), .BUS_NUM_I(4), .BUS_NUM_O(4)) if3 ();

    par2ser_stream #(.DATA_WIDTH(8), .BUS_NUM_I(8), .BUS_NUM_O(1), .LANE_ORDER(0))
        u0 (.clk(clk), .reset(reset), .io(if0));
    par2ser_stream #(.DATA_WIDTH(8), .BUS_NUM_I(8), .BUS_NUM_O(2), .LANE_ORDER(1))
        u1 (.clk(clk), .reset(reset), .io(if1));
    par2ser_stream #(.DATA_WIDTH(8), .BUS_NUM_I(8), .BUS_NUM_O(2), .LANE_ORDER(0))
        u2 (.clk(clk), .reset(reset), .io(if2));
    par2ser_stream #(.DATA_WIDTH(8), .BUS_NUM_I(4), .BUS_NUM_O(4), .LANE_ORDER(0))
        u3 (.clk(clk), .reset(reset), .io(if3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if0.data_valid_i = 1'b0; if0.data_ready_i = 1'b1;
        if1.data_valid_i = 1'b0; if1.data_ready_i = 1'b1;
        if2.data_valid_i = 1'b0; if2.data_ready_i = 1'b1;
        if3.data_valid_i = 1'b0; if3.data_ready_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if0.data_i[j] = '0; if1.data_i[j] = '0; if2.data_i[j] = '0;
        end
        for (int j = 0; j < 4; j++) if3.data_i[j] = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (if0.data_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if0.data_valid_o); end
        checks++; if (if0.first_o !== 1'b0) begin failures++; $display("FAIL reset_first got=%b exp=0", if0.first_o); end
        checks++; if (if0.last_o !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", if0.last_o); end
        checks++; if (if0.data_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", if0.data_ready_o); end
        checks++; if (if1.data_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid_u1 got=%b exp=0", if1.data_valid_o); end
        checks++; if (if3.data_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid_u3 got=%b exp=0", if3.data_valid_o); end
        step();
    endtask

    task automatic test_basic_strided();
        if0.data_ready_i = 1'b1;
        if0.data_valid_i = 1'b1;
        for (int j = 0; j < 8; j++) if0.data_i[j] = 8'(j);
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if (if0.data_ready_o !== 1'b1) begin failures++; $display("FAIL basic_accept_ready got=%b exp=1", if0.data_ready_o); end
            end else if (c <= 8) begin
                checks++; if (if0.data_valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid c=%0d got=%b exp=1", c, if0.data_valid_o); end
                checks++; if (if0.data_o[0] !== 8'(c - 1)) begin failures++; $display("FAIL basic_data c=%0d got=%0d exp=%0d", c, if0.data_o[0], c - 1); end
                checks++; if (if0.first_o !== (c == 1)) begin failures++; $display("FAIL basic_first c=%0d got=%b exp=%b", c, if0.first_o, (c == 1)); end
                checks++; if (if0.last_o !== (c == 8)) begin failures++; $display("FAIL basic_last c=%0d got=%b exp=%b", c, if0.last_o, (c == 8)); end
                checks++; if (if0.data_ready_o !== (c == 8)) begin failures++; $display("FAIL basic_ready c=%0d got=%b exp=%b", c, if0.data_ready_o, (c == 8)); end
            end else begin
                checks++; if (if0.data_valid_o !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", if0.data_valid_o); end
            end
            step();
            if (c == 0) if0.data_valid_i = 1'b0;
        end
    endtask

    task automatic test_lane_order();
        int exp_c [8] = '{10, 11, 12, 13, 14, 15, 16, 17};
        int exp_s [8] = '{10, 14, 11, 15, 12, 16, 13, 17};
        if1.data_ready_i = 1'b1; if2.data_ready_i = 1'b1;
        if1.data_valid_i = 1'b1; if2.data_valid_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if1.data_i[j] = 8'(10 + j);
            if2.data_i[j] = 8'(10 + j);
        end
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                for (int i = 0; i < 2; i++) begin
                    checks++; if (if1.data_o[i] !== 8'(exp_c[2*(c-1)+i])) begin failures++; $display("FAIL contig_data beat=%0d lane=%0d got=%0d exp=%0d", c - 1, i, if1.data_o[i], exp_c[2*(c-1)+i]); end
                    checks++; if (if2.data_o[i] !== 8'(exp_s[2*(c-1)+i])) begin failures++; $display("FAIL strided_data beat=%0d lane=%0d got=%0d exp=%0d", c - 1, i, if2.data_o[i], exp_s[2*(c-1)+i]); end
                end
                checks++; if (if1.last_o !== (c == 4)) begin failures++; $display("FAIL contig_last c=%0d got=%b exp=%b", c, if1.last_o, (c == 4)); end
                checks++; if (if2.first_o !== (c == 1)) begin failures++; $display("FAIL strided_first c=%0d got=%b exp=%b", c, if2.first_o, (c == 1)); end
            end else if (c == 5) begin
                checks++; if (if1.data_valid_o !== 1'b0 || if2.data_valid_o !== 1'b0) begin failures++; $display("FAIL order_idle got=%b%b exp=00", if1.data_valid_o, if2.data_valid_o); end
            end
            step();
            if (c == 0) begin if1.data_valid_i = 1'b0; if2.data_valid_i = 1'b0; end
        end
    endtask

    task automatic test_back_to_back();
        int  sent = 0;
        bit  acc;
        if0.data_ready_i = 1'b1;
        if0.data_valid_i = 1'b1;
        for (int j = 0; j < 8; j++) if0.data_i[j] = 8'(j);
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            acc = if0.data_valid_i && if0.data_ready_o;
            if (c == 8) begin
                checks++; if (acc !== 1'b1) begin failures++; $display("FAIL b2b_accept_on_last got=%b exp=1", acc); end
            end
            if (c >= 1 && c <= 16) begin
                checks++; if (if0.data_valid_o !== 1'b1 || if0.data_o[0] !== 8'(c - 1)) begin failures++; $display("FAIL b2b_beat c=%0d got=v%b/%0d exp=v1/%0d", c, if0.data_valid_o, if0.data_o[0], c - 1); end
                checks++; if (if0.first_o !== ((c - 1) % 8 == 0)) begin failures++; $display("FAIL b2b_first c=%0d got=%b", c, if0.first_o); end
            end
            if (c == 17) begin
                checks++; if (if0.data_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", if0.data_valid_o); end
            end
            step();
            if (acc) begin
                sent++;
                if (sent == 1) for (int j = 0; j < 8; j++) if0.data_i[j] = 8'(8 + j);
                else if0.data_valid_i = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        int         nxt = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_d = '0;
        logic       prev_f = 1'b0, prev_l = 1'b0;
        if0.data_valid_i = 1'b1;
        for (int j = 0; j < 8; j++) if0.data_i[j] = 8'(j);
        for (int c = 0; c < 40; c++) begin
            if0.data_ready_i = (c % 3 == 0);
            @(negedge clk);
            if (prev_stall) begin
                checks++; if (if0.data_o[0] !== prev_d || if0.first_o !== prev_f || if0.last_o !== prev_l) begin failures++; $display("FAIL bp_stall_hold c=%0d got=%0d/%b/%b exp=%0d/%b/%b", c, if0.data_o[0], if0.first_o, if0.last_o, prev_d, prev_f, prev_l); end
            end
            if (if0.data_valid_o && if0.data_ready_i) begin
                checks++; if (if0.data_o[0] !== 8'(nxt) || if0.first_o !== (nxt == 0) || if0.last_o !== (nxt == 7)) begin failures++; $display("FAIL bp_beat c=%0d got=%0d/%b/%b exp=%0d", c, if0.data_o[0], if0.first_o, if0.last_o, nxt); end
                nxt++;
            end
            prev_stall = if0.data_valid_o && !if0.data_ready_i;
            prev_d = if0.data_o[0]; prev_f = if0.first_o; prev_l = if0.last_o;
            if (if0.data_valid_i && if0.data_ready_o) begin
                step();
                if0.data_valid_i = 1'b0;
            end else begin
                step();
            end
        end
        checks++; if (nxt != 8) begin failures++; $display("FAIL bp_beat_count got=%0d exp=8", nxt); end
        checks++; if (if0.data_valid_o !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", if0.data_valid_o); end
        if0.data_ready_i = 1'b1;
    endtask

    task automatic test_reset_mid_word();
        if0.data_ready_i = 1'b1;
        if0.data_valid_i = 1'b1;
        for (int j = 0; j < 8; j++) if0.data_i[j] = 8'(j);
        step();
        if0.data_valid_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks++; if (if0.data_o[0] !== 8'd3) begin failures++; $display("FAIL rst_pre_beat got=%0d exp=3", if0.data_o[0]); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        if0.data_valid_i = 1'b1;
        for (int j = 0; j < 8; j++) if0.data_i[j] = 8'(20 + j);
        @(negedge clk);
        checks++; if (if0.data_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", if0.data_valid_o); end
        checks++; if (if0.data_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", if0.data_ready_o); end
        step();
        if0.data_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (if0.data_valid_o !== 1'b1 || if0.data_o[0] !== 8'd20 || if0.first_o !== 1'b1) begin failures++; $display("FAIL rst_next_word got=v%b/%0d/f%b exp=v1/20/f1", if0.data_valid_o, if0.data_o[0], if0.first_o); end
        repeat (9) step();
    endtask

    task automatic test_degenerate();
        logic [7:0] w [5][4];
        bit         ok;
        for (int n = 0; n < 5; n++)
            for (int j = 0; j < 4; j++) w[n][j] = 8'($urandom_range(0, 255));
        if3.data_ready_i = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c < 5) begin
                if3.data_valid_i = 1'b1;
                for (int j = 0; j < 4; j++) if3.data_i[j] = w[c][j];
            end else begin
                if3.data_valid_i = 1'b0;
            end
            @(negedge clk);
            if (c <= 5) begin
                checks++; if (if3.data_ready_o !== 1'b1) begin failures++; $display("FAIL nb1_ready c=%0d got=%b exp=1", c, if3.data_ready_o); end
            end
            if (c >= 1 && c <= 5) begin
                ok = 1'b1;
                for (int j = 0; j < 4; j++) if (if3.data_o[j] !== w[c-1][j]) ok = 1'b0;
                checks++; if (!ok || if3.data_valid_o !== 1'b1) begin failures++; $display("FAIL nb1_data c=%0d got=v%b/%0d exp=v1/%0d", c, if3.data_valid_o, if3.data_o[0], w[c-1][0]); end
                checks++; if (if3.first_o !== 1'b1 || if3.last_o !== 1'b1) begin failures++; $display("FAIL nb1_flags c=%0d got=%b%b exp=11", c, if3.first_o, if3.last_o); end
            end
            if (c == 6) begin
                checks++; if (if3.data_valid_o !== 1'b0) begin failures++; $display("FAIL nb1_idle got=%b exp=0", if3.data_valid_o); end
            end
            step();
        end
    endtask

    // Reference: each accepted word becomes a list of {first,last,lane1,lane0} beats.
    task automatic test_random_stream();
        logic [17:0] q1 [$];
        logic [17:0] q2 [$];
        logic [7:0]  w [8];
        logic [17:0] got, expv;
        bit          vld, rdy, acc1, acc2, exp_rdy;
        for (int c = 0; c < 340; c++) begin
            if (c < 300) begin
                vld = ($urandom_range(0, 9) < 6);
                rdy = ($urandom_range(0, 9) < 7);
            end else begin
                vld = 1'b0;
                rdy = 1'b1;
            end
            for (int j = 0; j < 8; j++) w[j] = 8'($urandom_range(0, 255));
            if1.data_valid_i = vld; if2.data_valid_i = vld;
            if1.data_ready_i = rdy; if2.data_ready_i = rdy;
            for (int j = 0; j < 8; j++) begin if1.data_i[j] = w[j]; if2.data_i[j] = w[j]; end
            @(negedge clk);
            exp_rdy = (q1.size() == 0) || (q1.size() == 1 && rdy);
            checks++; if (if1.data_ready_o !== exp_rdy || if1.data_valid_o !== (q1.size() != 0)) begin failures++; $display("FAIL rnd_hs_contig c=%0d got=r%b/v%b exp=r%b/v%b", c, if1.data_ready_o, if1.data_valid_o, exp_rdy, (q1.size() != 0)); end
            exp_rdy = (q2.size() == 0) || (q2.size() == 1 && rdy);
            checks++; if (if2.data_ready_o !== exp_rdy || if2.data_valid_o !== (q2.size() != 0)) begin failures++; $display("FAIL rnd_hs_strided c=%0d got=r%b/v%b exp=r%b/v%b", c, if2.data_ready_o, if2.data_valid_o, exp_rdy, (q2.size() != 0)); end
            acc1 = vld && if1.data_ready_o;
            acc2 = vld && if2.data_ready_o;
            if (if1.data_valid_o && rdy) begin
                got = {if1.first_o, if1.last_o, if1.data_o[1], if1.data_o[0]};
                expv = (q1.size() != 0) ? q1.pop_front() : 18'h3ffff;
                checks++; if (got !== expv) begin failures++; $display("FAIL rnd_beat_contig c=%0d got=%h exp=%h", c, got, expv); end
            end
            if (if2.data_valid_o && rdy) begin
                got = {if2.first_o, if2.last_o, if2.data_o[1], if2.data_o[0]};
                expv = (q2.size() != 0) ? q2.pop_front() : 18'h3ffff;
                checks++; if (got !== expv) begin failures++; $display("FAIL rnd_beat_strided c=%0d got=%h exp=%h", c, got, expv); end
            end
            for (int k = 0; k < 4; k++) begin
                if (acc1) q1.push_back({(k == 0), (k == 3), w[2*k+1], w[2*k]});
                if (acc2) q2.push_back({(k == 0), (k == 3), w[k+4], w[k]});
            end
            step();
        end
        checks++; if (q1.size() != 0 || q2.size() != 0) begin failures++; $display("FAIL rnd_undelivered got=%0d/%0d exp=0/0", q1.size(), q2.size()); end
        idle_all();
    endtask

    initial begin
        reset = 1'b1;
        idle_all();
        test_reset();
        test_basic_strided();
        test_lane_order();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_degenerate();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
